// File: rtl/reg_file_16x16.sv
// 16x16 general-purpose register file: one-hot decoded write, two bypassed
// combinational read ports, and a per-register pending-write scoreboard.
module reg_file_16x16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] wordline,
   input  logic [15:0] wr_data,
   input  logic [3:0]  rd_addr_a,
   input  logic [3:0]  rd_addr_b,
   output logic [15:0] rd_data_a,
   output logic [15:0] rd_data_b,
   input  logic        busy_set_en,
   input  logic [3:0]  busy_set_id,
   output logic        busy_a,
   output logic        busy_b,
   output logic        wl_err
);

   logic [15:0] regs_q [16];
   logic [15:0] regs_d [16];
   logic [15:0] busy_q, busy_d;
   logic        wl_err_q, wl_err_d;

   logic wl_multi;
   logic wl_legal;
   logic byp_a, byp_b;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign wl_multi = |(wordline & (wordline - 16'd1));
   assign wl_legal = (|wordline) & ~wl_multi;

   assign byp_a = wl_legal & wordline[rd_addr_a];
   assign byp_b = wl_legal & wordline[rd_addr_b];

   always_comb begin
      regs_d   = regs_q;
      busy_d   = busy_q;
      wl_err_d = wl_err_q | wl_multi;
      for (int k = 1; k < 16; k++) begin
         if (wl_legal && wordline[k]) begin
            regs_d[k] = wr_data;
            busy_d[k] = 1'b0;
         end
      end
      // Set after clear so a newly issued producer wins over the retiring one.
      if (busy_set_en && (busy_set_id != 4'd0)) begin
         busy_d[busy_set_id] = 1'b1;
      end
      regs_d[0] = 16'd0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            regs_q[k] <= 16'd0;
         end
         busy_q   <= 16'd0;
         wl_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         busy_q   <= busy_d;
         wl_err_q <= wl_err_d;
      end
   end

   always_comb begin
      rd_data_a = 16'd0;
      if (rd_addr_a != 4'd0) begin
         rd_data_a = byp_a ? wr_data : regs_q[rd_addr_a];
      end
   end

   always_comb begin
      rd_data_b = 16'd0;
      if (rd_addr_b != 4'd0) begin
         rd_data_b = byp_b ? wr_data : regs_q[rd_addr_b];
      end
   end

   // busy_q[0] is held at zero, so address 0 never reports busy.
   assign busy_a = busy_q[rd_addr_a] & ~byp_a;
   assign busy_b = busy_q[rd_addr_b] & ~byp_b;
   assign wl_err = wl_err_q;

endmodule

// File: tb/tb_reg_file_16x16.sv
// Self-checking bench for reg_file_16x16: per-cycle vector table plus a
// randomized write/readback pass, with expectations routed through a queue.
module tb_reg_file_16x16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] wordline;
   logic [15:0] wr_data;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic        busy_set_en;
   logic [3:0]  busy_set_id;
   logic        busy_a;
   logic        busy_b;
   logic        wl_err;

   always #5 clk = ~clk;

   reg_file_16x16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wordline    (wordline),
      .wr_data     (wr_data),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .rd_data_a   (rd_data_a),
      .rd_data_b   (rd_data_b),
      .busy_set_en (busy_set_en),
      .busy_set_id (busy_set_id),
      .busy_a      (busy_a),
      .busy_b      (busy_b),
      .wl_err      (wl_err)
   );

   typedef struct {
      string       name;
      logic        rst_n;
      logic [15:0] wl;
      logic [15:0] wd;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic        se;
      logic [3:0]  sid;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        eba;
      logic        ebb;
      logic        eerr;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        eba;
      logic        ebb;
      logic        eerr;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;

   task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
      end
   endtask

   task automatic drive(input logic rn, input logic [15:0] wl, input logic [15:0] wd,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic se, input logic [3:0] sid, input exp_t e);
      rst_n       = rn;
      wordline    = wl;
      wr_data     = wd;
      rd_addr_a   = ra;
      rd_addr_b   = rb;
      busy_set_en = se;
      busy_set_id = sid;
      exp_q.push_back(e);
   endtask

   // Outputs are sampled mid-cycle, then the clock edge commits the cycle.
   task automatic check_cycle();
      exp_t e;
      @(negedge clk);
      if (exp_q.size() == 0) begin
         tests++;
         failed++;
         $display("FAIL scoreboard empty got 0 expected 1");
      end else begin
         e = exp_q.pop_front();
         cmp(e.name, "rd_data_a", rd_data_a, e.ea);
         cmp(e.name, "rd_data_b", rd_data_b, e.eb);
         cmp(e.name, "busy_a", {15'd0, busy_a}, {15'd0, e.eba});
         cmp(e.name, "busy_b", {15'd0, busy_b}, {15'd0, e.ebb});
         cmp(e.name, "wl_err", {15'd0, wl_err}, {15'd0, e.eerr});
      end
      @(posedge clk);
      #1;
   endtask

   logic [15:0] mregs [16];
   logic [15:0] mbusy;

   initial begin
      exp_t e;
      //             name           rst  wl        wd        ra  rb  se  sid  ea        eb        ba  bb  err
      vecs.push_back('{"reset_state", 1, 16'h0000, 16'h0000, 3, 7, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
      vecs.push_back('{"bypass_r3",   1, 16'h0008, 16'hBEEF, 3, 0, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 0});
      vecs.push_back('{"hold_r3",     1, 16'h0000, 16'h0000, 3, 3, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 0});
      vecs.push_back('{"r0_write",    1, 16'h0001, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
      vecs.push_back('{"r0_after",    1, 16'h0000, 16'h0000, 0, 3, 0, 0, 16'h0000, 16'hBEEF, 0, 0, 0});
      vecs.push_back('{"write_r5",    1, 16'h0020, 16'h00AA, 5, 4, 0, 0, 16'h00AA, 16'h0000, 0, 0, 0});
      vecs.push_back('{"multi_hot",   1, 16'h0030, 16'hFFFF, 4, 5, 0, 0, 16'h0000, 16'h00AA, 0, 0, 0});
      vecs.push_back('{"after_multi", 1, 16'h0000, 16'h0000, 4, 5, 0, 0, 16'h0000, 16'h00AA, 0, 0, 1});
      vecs.push_back('{"set_busy7",   1, 16'h0000, 16'h0000, 7, 7, 1, 7, 16'h0000, 16'h0000, 0, 0, 1});
      vecs.push_back('{"busy7",       1, 16'h0000, 16'h0000, 7, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1});
      vecs.push_back('{"wb7",         1, 16'h0080, 16'h7777, 7, 7, 0, 0, 16'h7777, 16'h7777, 0, 0, 1});
      vecs.push_back('{"after_wb7",   1, 16'h0000, 16'h0000, 7, 7, 0, 0, 16'h7777, 16'h7777, 0, 0, 1});
      vecs.push_back('{"set_wins9",   1, 16'h0200, 16'h9999, 9, 9, 1, 9, 16'h9999, 16'h9999, 0, 0, 1});
      vecs.push_back('{"busy9",       1, 16'h0000, 16'h0000, 9, 0, 0, 0, 16'h9999, 16'h0000, 1, 0, 1});
      vecs.push_back('{"set_id0",     1, 16'h0000, 16'h0000, 0, 9, 1, 0, 16'h0000, 16'h9999, 0, 1, 1});
      vecs.push_back('{"w_r2_set2",   1, 16'h0004, 16'h5555, 2, 0, 1, 2, 16'h5555, 16'h0000, 0, 0, 1});
      vecs.push_back('{"busy2_rst",   0, 16'h0000, 16'h0000, 2, 9, 0, 0, 16'h5555, 16'h9999, 1, 1, 1});
      vecs.push_back('{"after_rst",   1, 16'h0000, 16'h0000, 2, 9, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
      vecs.push_back('{"in_rst_ops",  0, 16'h0020, 16'h1111, 1, 1, 1, 5, 16'h0000, 16'h0000, 0, 0, 0});
      vecs.push_back('{"rst_ignored", 1, 16'h0000, 16'h0000, 5, 5, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
      vecs.push_back('{"set_busy4",   1, 16'h0000, 16'h0000, 4, 0, 1, 4, 16'h0000, 16'h0000, 0, 0, 0});
      vecs.push_back('{"multi_busy4", 1, 16'h0030, 16'hFFFF, 4, 5, 0, 0, 16'h0000, 16'h0000, 1, 0, 0});
      vecs.push_back('{"busy4_kept",  1, 16'h0000, 16'h0000, 4, 5, 0, 0, 16'h0000, 16'h0000, 1, 0, 1});

      rst_n = 1'b0; wordline = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
      busy_set_en = 1'b0; busy_set_id = '0;
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         e = '{vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].eba, vecs[i].ebb, vecs[i].eerr};
         drive(vecs[i].rst_n, vecs[i].wl, vecs[i].wd, vecs[i].ra, vecs[i].rb,
               vecs[i].se, vecs[i].sid, e);
         check_cycle();
      end

      // State left by the table: all registers zero, R4 pending, error latched.
      for (int k = 0; k < 16; k++) mregs[k] = 16'd0;
      mbusy = 16'h0010;

      for (int k = 1; k < 16; k++) begin
         logic [15:0] wd;
         logic [3:0]  rb;
         wd = 16'($urandom);
         rb = 4'($urandom_range(15, 0));
         e.name = "rand_write";
         e.ea   = wd;
         e.eba  = 1'b0;
         e.eb   = (rb == 4'd0) ? 16'd0 : (rb == 4'(k)) ? wd : mregs[rb];
         e.ebb  = (rb != 4'd0) && (rb != 4'(k)) && mbusy[rb];
         e.eerr = 1'b1;
         drive(1'b1, 16'(1) << k, wd, 4'(k), rb, 1'b0, 4'd0, e);
         check_cycle();
         mregs[k] = wd;
         mbusy[k] = 1'b0;
      end

      for (int n = 0; n < 16; n++) begin
         logic [3:0] ra, rb;
         ra = 4'($urandom_range(15, 0));
         rb = 4'($urandom_range(15, 0));
         e.name = "rand_read";
         e.ea   = mregs[ra];
         e.eb   = mregs[rb];
         e.eba  = 1'b0;
         e.ebb  = 1'b0;
         e.eerr = 1'b1;
         drive(1'b1, 16'd0, 16'd0, ra, rb, 1'b0, 4'd0, e);
         check_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
